ssd1306_spi_rx: RTL and testbench
=================================

Name: ssd1306_spi_rx

Overview:
- Receive-side front end of the SSD1306 emulation, between the MCU's OLED SPI pins (OledCS, OledSCL, OledMOSI, OledDC) and the ssd1306 frame buffer/raster block.
- Oversamples the raw SPI lines, assembles bytes, decodes the SSD1306 command set and GDDRAM addressing, and emits one-cycle VRAM write strobes plus display-control registers.

Parameters:
- X_OLED_SIZE, 128, columns per page.
- Y_OLED_SIZE, 64, rows; pages = Y_OLED_SIZE/8.
- SYNC_STAGES, 2, synchroniser flops on ss/scl/mosi/dc; minimum 2.

Ports:
- clk_i  in  1  oversampling clock; must be ≥4× SCL frequency (pll_clk class).
- rst_i  in  1  asynchronous, active-low reset.
- ss_i  in  1  raw chip select, active-low.
- scl_i  in  1  raw SPI clock.
- mosi_i  in  1  raw SPI data.
- dc_i  in  1  raw data/command select (1 = data).
- vram_addr_o  out  $clog2(X_OLED_SIZE*Y_OLED_SIZE/8)  page*X_OLED_SIZE + column.
- vram_data_o  out  8  GDDRAM byte.
- vram_we_o  out  1  one-cycle write strobe.
- display_on_o  out  1  0xAE/0xAF state.
- invert_o  out  1  0xA6/0xA7 state.
- contrast_o  out  8  0x81 argument.
- addr_mode_o  out  2  0 = horizontal, 1 = vertical, 2 = page.

Behaviour:
- Reset (async, rst_i=0) clears all state to:
  - vram_addr_o=0, vram_data_o=0, vram_we_o=0.
  - display_on_o=0, invert_o=0, contrast_o=8'h7F, addr_mode_o=2.
  - col_start=0, col_end=X-1, page_start=0, page_end=pages-1, col=0, page=0.
  - FSM in IDLE.
- Sampling: SPI mode 0, MSB first. MOSI and DC are sampled on the synchronised SCL rising edge.
- ss high: bit counter is held at 0; a partial byte is discarded. Command FSM state persists across CS toggles.
- Byte complete on the 8th sampled bit; DC is taken from that 8th sample.
- Latency: vram_we_o asserts exactly SYNC_STAGES+2 clk_i cycles after the 8th SCL rise at the pins.
- Data byte (DC=1):
  - Write {addr(col,page), byte}, then advance the pointer.
  - A data byte arriving while the FSM awaits an argument aborts the FSM to IDLE; the byte is still written.
- Pointer advance:
  - Horizontal: col++. At col_end: col←col_start, page++. At page_end with col_end: page←page_start.
  - Vertical: page++. At page_end: page←page_start, col++. At col_end with page_end: col←col_start.
  - Page: col++. At col_end: col←col_start; page unchanged.
- Command FSM states:
  - IDLE
  - ARG1 (single-argument commands)
  - COL_S, COL_E, PAGE_S, PAGE_E
- Commands handled in IDLE:
  - 0xAE/0xAF: display_on_o.
  - 0xA6/0xA7: invert_o.
  - 0x81: go to ARG1; argument → contrast_o.
  - 0x20: go to ARG1; argument[1:0] → addr_mode_o. Value 3 is ignored (mode kept).
  - 0x21 → COL_S → COL_E: load col_start/col_end (masked to column width); col←col_start.
  - 0x22 → PAGE_S → PAGE_E: load page_start/page_end (masked to page width); page←page_start.
  - 0x00–0x0F: col[3:0]. 0x10–0x1F: col[7:4] (clipped to width). 0xB0–0xB7: page.
  - 0xD5, 0xA8, 0xD3, 0x8D, 0xDA, 0xD9, 0xDB: go to ARG1; argument is consumed and ignored.
  - All other opcodes: no-op.
- Column/page writes with a start value greater than the end value are stored as given; wrap compares use equality only.

Optional Feature:
- Macro: SSD1306_SPI_RX_REMAP_EN.
- Defined:
  - Adds outputs seg_remap_o (0xA0→0, 0xA1→1) and com_rev_o (0xC0→0, 0xC8→1).
  - Both reset to 0.
- Undefined:
  - Ports are absent.
  - 0xA0, 0xA1, 0xC0, 0xC8 are no-ops.

Decomposition:
- Package ssd1306_pkg holds:
  - Opcode constants.
  - FSM state encoding.
  - Addressing-mode encodings.
  - Reset contrast value.
- Sub-module spi_byte_rx contains the synchronisers, SCL edge detect, shift register and bit counter. It outputs byte, dc and a byte_valid strobe.

Test Plan:
- Reset, then send data 0x55 with DC=1 → vram_we_o pulse with addr 0, data 0x55, SYNC_STAGES+2 cycles after the 8th SCL edge; next write lands at addr 1.
- Commands 0x20,0x00 / 0x21,0x7E,0x7F / 0x22,0x06,0x07, then 4 data bytes → addrs 6*128+126, 6*128+127, 7*128+126, 7*128+127.
- Vertical mode, full range, 9 data bytes → addrs 0,128,…,896, then 1.
- Page mode with 0xB3, 0x05, 0x12 → next write at addr 3*128+0x25.
- ss_i raised after 5 bits, then a full byte 0xAF with DC=0 → display_on_o=1 and no vram_we_o.
- 0x81 followed by data 0x33 → FSM aborts, write of 0x33 occurs, contrast_o stays 0x7F; rst_i low mid-byte → all outputs return to reset values immediately.

Source files
------------

// File: rtl/ssd1306_pkg.sv
// ---------------------------------------------------------------------------
// ssd1306_pkg
// Shared definitions for the SSD1306 SPI receive front end:
//   - SSD1306 opcode constants handled by the command decoder
//   - command FSM state encoding
//   - GDDRAM addressing-mode encodings
//   - reset value of the contrast register
// ---------------------------------------------------------------------------
package ssd1306_pkg;

    // Fundamental commands
    localparam logic [7:0] OP_DISPLAY_OFF  = 8'hAE;
    localparam logic [7:0] OP_DISPLAY_ON   = 8'hAF;
    localparam logic [7:0] OP_NORMAL       = 8'hA6;
    localparam logic [7:0] OP_INVERT       = 8'hA7;
    localparam logic [7:0] OP_CONTRAST     = 8'h81;

    // Addressing commands
    localparam logic [7:0] OP_ADDR_MODE    = 8'h20;
    localparam logic [7:0] OP_COL_ADDR     = 8'h21;
    localparam logic [7:0] OP_PAGE_ADDR    = 8'h22;

    // Hardware-configuration commands whose single argument is swallowed
    localparam logic [7:0] OP_CLK_DIV      = 8'hD5;
    localparam logic [7:0] OP_MUX_RATIO    = 8'hA8;
    localparam logic [7:0] OP_DISP_OFFSET  = 8'hD3;
    localparam logic [7:0] OP_CHARGE_PUMP  = 8'h8D;
    localparam logic [7:0] OP_COM_PINS     = 8'hDA;
    localparam logic [7:0] OP_PRECHARGE    = 8'hD9;
    localparam logic [7:0] OP_VCOMH        = 8'hDB;

    // Orientation commands (only acted upon when remapping is built in)
    localparam logic [7:0] OP_SEG_REMAP0   = 8'hA0;
    localparam logic [7:0] OP_SEG_REMAP1   = 8'hA1;
    localparam logic [7:0] OP_COM_NORMAL   = 8'hC0;
    localparam logic [7:0] OP_COM_REV      = 8'hC8;

    // Command FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARG1   = 3'd1,
        ST_COL_S  = 3'd2,
        ST_COL_E  = 3'd3,
        ST_PAGE_S = 3'd4,
        ST_PAGE_E = 3'd5
    } cmd_state_t;

    // Memory addressing modes (value 3 is invalid and never stored)
    localparam logic [1:0] MODE_HORIZ = 2'd0;
    localparam logic [1:0] MODE_VERT  = 2'd1;
    localparam logic [1:0] MODE_PAGE  = 2'd2;

    localparam logic [7:0] CONTRAST_RST = 8'h7F;

    // Opcodes that take one argument byte which this model does not use.
    function automatic logic is_ignored_arg_op(input logic [7:0] op);
        case (op)
            OP_CLK_DIV, OP_MUX_RATIO, OP_DISP_OFFSET, OP_CHARGE_PUMP,
            OP_COM_PINS, OP_PRECHARGE, OP_VCOMH: is_ignored_arg_op = 1'b1;
            default:                             is_ignored_arg_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// ---------------------------------------------------------------------------
// spi_byte_rx
// Oversampling SPI (mode 0, MSB first) byte receiver. All four raw SPI lines
// pass through SYNC_STAGES-deep synchronisers; MOSI and DC are sampled on the
// synchronised SCL rising edge. While chip select is high the bit counter is
// held at zero so any partial byte is discarded.
//
// Ports:
//   clk_i         oversampling clock (>= 4x SCL)
//   rst_i         asynchronous reset, active low
//   ss_i          raw chip select, active low
//   scl_i         raw SPI clock
//   mosi_i        raw SPI data
//   dc_i          raw data/command select (1 = data)
//   byte_o        last complete byte
//   dc_o          DC level captured with the 8th bit of byte_o
//   byte_valid_o  one-cycle strobe, byte_o/dc_o valid
// ---------------------------------------------------------------------------
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ss_i,
    input  logic       scl_i,
    input  logic       mosi_i,
    input  logic       dc_i,
    output logic [7:0] byte_o,
    output logic       dc_o,
    output logic       byte_valid_o
);

    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] dc_sync;
    logic                   scl_prev;
    logic [6:0]             shift;
    logic [2:0]             bit_cnt;

    logic ss_s;
    logic scl_s;
    logic mosi_s;
    logic dc_s;
    logic scl_rise;

    assign ss_s     = ss_sync[SYNC_STAGES-1];
    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign dc_s     = dc_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            // Chip select resets to its inactive (high) level.
            ss_sync      <= '1;
            scl_sync     <= '0;
            mosi_sync    <= '0;
            dc_sync      <= '0;
            scl_prev     <= 1'b0;
            shift        <= '0;
            bit_cnt      <= '0;
            byte_o       <= '0;
            dc_o         <= 1'b0;
            byte_valid_o <= 1'b0;
        end else begin
            ss_sync      <= {ss_sync[SYNC_STAGES-2:0],   ss_i};
            scl_sync     <= {scl_sync[SYNC_STAGES-2:0],  scl_i};
            mosi_sync    <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            dc_sync      <= {dc_sync[SYNC_STAGES-2:0],   dc_i};
            scl_prev     <= scl_s;
            byte_valid_o <= 1'b0;

            if (ss_s) begin
                bit_cnt <= '0;
            end else if (scl_rise) begin
                shift <= {shift[5:0], mosi_s};
                // The 3-bit counter wraps to 0 after the 8th bit.
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_o       <= {shift, mosi_s};
                    dc_o         <= dc_s;
                    byte_valid_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ssd1306_spi_rx.sv
// ---------------------------------------------------------------------------
// ssd1306_spi_rx
// Receive-side front end of the SSD1306 emulation. Turns the MCU's raw OLED
// SPI lines into GDDRAM write strobes and display-control registers.
//
// Optional build macro: SSD1306_SPI_RX_REMAP_EN adds seg_remap_o / com_rev_o
// driven by 0xA0/0xA1 and 0xC0/0xC8; without it those opcodes are no-ops.
//
// Ports:
//   clk_i         oversampling clock (>= 4x SCL)
//   rst_i         asynchronous reset, active low
//   ss_i          raw chip select, active low
//   scl_i         raw SPI clock
//   mosi_i        raw SPI data
//   dc_i          raw data/command select (1 = data)
//   vram_addr_o   GDDRAM address, page*X_OLED_SIZE + column
//   vram_data_o   GDDRAM byte
//   vram_we_o     one-cycle write strobe
//   display_on_o  0xAE/0xAF state
//   invert_o      0xA6/0xA7 state
//   contrast_o    0x81 argument
//   addr_mode_o   0 horizontal, 1 vertical, 2 page
//   seg_remap_o   (remap build only) 0xA0/0xA1 state
//   com_rev_o     (remap build only) 0xC0/0xC8 state
// ---------------------------------------------------------------------------
module ssd1306_spi_rx
    import ssd1306_pkg::*;
#(
    parameter int X_OLED_SIZE = 128,
    parameter int Y_OLED_SIZE = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      ss_i,
    input  logic                                      scl_i,
    input  logic                                      mosi_i,
    input  logic                                      dc_i,
    output logic [$clog2(X_OLED_SIZE*Y_OLED_SIZE/8)-1:0] vram_addr_o,
    output logic [7:0]                                vram_data_o,
    output logic                                      vram_we_o,
    output logic                                      display_on_o,
    output logic                                      invert_o,
    output logic [7:0]                                contrast_o,
    output logic [1:0]                                addr_mode_o
`ifdef SSD1306_SPI_RX_REMAP_EN
    ,
    output logic                                      seg_remap_o,
    output logic                                      com_rev_o
`endif
);

    localparam int PAGES = Y_OLED_SIZE / 8;
    localparam int AW    = $clog2(X_OLED_SIZE * Y_OLED_SIZE / 8);
    localparam int CW    = $clog2(X_OLED_SIZE);
    localparam int PW    = (PAGES > 1) ? $clog2(PAGES) : 1;

    logic [7:0] rx_byte;
    logic       rx_dc;
    logic       rx_valid;

    cmd_state_t    state;
    logic [7:0]    arg_op;      // opcode awaiting its argument in ST_ARG1
    logic [CW-1:0] col_start;
    logic [CW-1:0] col_end;
    logic [PW-1:0] page_start;
    logic [PW-1:0] page_end;
    logic [CW-1:0] col;
    logic [PW-1:0] page;

    function automatic logic [AW-1:0] gddram_addr(input logic [PW-1:0] p,
                                                  input logic [CW-1:0] c);
        return AW'(p) * AW'(X_OLED_SIZE) + AW'(c);
    endfunction

    spi_byte_rx #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_byte_rx (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ss_i         (ss_i),
        .scl_i        (scl_i),
        .mosi_i       (mosi_i),
        .dc_i         (dc_i),
        .byte_o       (rx_byte),
        .dc_o         (rx_dc),
        .byte_valid_o (rx_valid)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vram_addr_o  <= '0;
            vram_data_o  <= '0;
            vram_we_o    <= 1'b0;
            display_on_o <= 1'b0;
            invert_o     <= 1'b0;
            contrast_o   <= CONTRAST_RST;
            addr_mode_o  <= MODE_PAGE;
`ifdef SSD1306_SPI_RX_REMAP_EN
            seg_remap_o  <= 1'b0;
            com_rev_o    <= 1'b0;
`endif
            state        <= ST_IDLE;
            arg_op       <= '0;
            col_start    <= '0;
            col_end      <= CW'(X_OLED_SIZE - 1);
            page_start   <= '0;
            page_end     <= PW'(PAGES - 1);
            col          <= '0;
            page         <= '0;
        end else begin
            vram_we_o <= 1'b0;

            if (rx_valid && rx_dc) begin
                // GDDRAM data: write at the current pointer, then advance.
                // A pending argument is abandoned.
                vram_addr_o <= gddram_addr(page, col);
                vram_data_o <= rx_byte;
                vram_we_o   <= 1'b1;
                state       <= ST_IDLE;

                if (addr_mode_o == MODE_HORIZ) begin
                    if (col == col_end) begin
                        col  <= col_start;
                        page <= (page == page_end) ? page_start : page + PW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end else if (addr_mode_o == MODE_VERT) begin
                    if (page == page_end) begin
                        page <= page_start;
                        col  <= (col == col_end) ? col_start : col + CW'(1);
                    end else begin
                        page <= page + PW'(1);
                    end
                end else begin
                    col <= (col == col_end) ? col_start : col + CW'(1);
                end
            end else if (rx_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_byte[7:4] == 4'h0) begin
                            col <= (col & ~CW'(4'hF)) | CW'(rx_byte[3:0]);
                        end else if (rx_byte[7:4] == 4'h1) begin
                            // High nibble is clipped to the column width.
                            col <= CW'({rx_byte[3:0], col[3:0]});
                        end else if (rx_byte[7:3] == 5'b10110) begin
                            page <= PW'(rx_byte[2:0]);
                        end else begin
                            case (rx_byte)
                                OP_DISPLAY_OFF: display_on_o <= 1'b0;
                                OP_DISPLAY_ON:  display_on_o <= 1'b1;
                                OP_NORMAL:      invert_o     <= 1'b0;
                                OP_INVERT:      invert_o     <= 1'b1;
                                OP_COL_ADDR:    state        <= ST_COL_S;
                                OP_PAGE_ADDR:   state        <= ST_PAGE_S;
`ifdef SSD1306_SPI_RX_REMAP_EN
                                OP_SEG_REMAP0:  seg_remap_o  <= 1'b0;
                                OP_SEG_REMAP1:  seg_remap_o  <= 1'b1;
                                OP_COM_NORMAL:  com_rev_o    <= 1'b0;
                                OP_COM_REV:     com_rev_o    <= 1'b1;
`endif
                                default: begin
                                    if (rx_byte == OP_CONTRAST ||
                                        rx_byte == OP_ADDR_MODE ||
                                        is_ignored_arg_op(rx_byte)) begin
                                        arg_op <= rx_byte;
                                        state  <= ST_ARG1;
                                    end
                                end
                            endcase
                        end
                    end
                    ST_ARG1: begin
                        if (arg_op == OP_CONTRAST) begin
                            contrast_o <= rx_byte;
                        end else if (arg_op == OP_ADDR_MODE &&
                                     rx_byte[1:0] != 2'd3) begin
                            addr_mode_o <= rx_byte[1:0];
                        end
                        state <= ST_IDLE;
                    end
                    ST_COL_S: begin
                        col_start <= CW'(rx_byte);
                        state     <= ST_COL_E;
                    end
                    ST_COL_E: begin
                        col_end <= CW'(rx_byte);
                        col     <= col_start;
                        state   <= ST_IDLE;
                    end
                    ST_PAGE_S: begin
                        page_start <= PW'(rx_byte);
                        state      <= ST_PAGE_E;
                    end
                    ST_PAGE_E: begin
                        page_end <= PW'(rx_byte);
                        page     <= page_start;
                        state    <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ssd1306_spi_rx.sv
// ---------------------------------------------------------------------------
// tb_ssd1306_spi_rx
// Directed bench for ssd1306_spi_rx: drives SPI mode-0 traffic at 1/8 of the
// clock rate and checks GDDRAM writes, write latency and control registers.
// ---------------------------------------------------------------------------
module tb_ssd1306_spi_rx;

    localparam int SYNC = 2;

    logic       clk;
    logic       rst_n;
    logic       ss;
    logic       scl;
    logic       mosi;
    logic       dc;
    logic [9:0] vram_addr;
    logic [7:0] vram_data;
    logic       vram_we;
    logic       display_on;
    logic       invert;
    logic [7:0] contrast;
    logic [1:0] addr_mode;
`ifdef SSD1306_SPI_RX_REMAP_EN
    logic       seg_remap;
    logic       com_rev;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_rise = 0;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
        int         lat;
    } wr_t;
    wr_t wq[$];

    ssd1306_spi_rx #(
        .X_OLED_SIZE (128),
        .Y_OLED_SIZE (64),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .ss_i         (ss),
        .scl_i        (scl),
        .mosi_i       (mosi),
        .dc_i         (dc),
        .vram_addr_o  (vram_addr),
        .vram_data_o  (vram_data),
        .vram_we_o    (vram_we),
        .display_on_o (display_on),
        .invert_o     (invert),
        .contrast_o   (contrast),
        .addr_mode_o  (addr_mode)
`ifdef SSD1306_SPI_RX_REMAP_EN
        ,
        .seg_remap_o  (seg_remap),
        .com_rev_o    (com_rev)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe with its distance from the latest SCL rise.
    always @(negedge clk) begin
        if (vram_we === 1'b1) wq.push_back('{vram_addr, vram_data, cyc - last_rise});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with SCL low.
    task automatic send_bit(input logic b, input logic dcv);
        mosi = b;
        dc   = dcv;
        scl  = 1'b0;
        repeat (4) @(negedge clk);
        scl = 1'b1;
        last_rise = cyc;
        repeat (4) @(negedge clk);
        scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dcv);
        for (int i = 7; i >= 0; i--) send_bit(b[i], dcv);
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_write(input string tag, input logic [9:0] addr, input logic [7:0] data);
        wr_t w;
        chk({tag, "_present"}, wq.size(), 1);
        if (wq.size() > 0) begin
            w = wq.pop_front();
            chk({tag, "_addr"}, w.addr, addr);
            chk({tag, "_data"}, w.data, data);
            chk({tag, "_latency"}, w.lat, SYNC + 2);
        end
        wq.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        ss    = 1'b1;
        scl   = 1'b0;
        mosi  = 1'b0;
        dc    = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_addr",     vram_addr,  0);
        chk("rst_data",     vram_data,  0);
        chk("rst_we",       vram_we,    0);
        chk("rst_disp",     display_on, 0);
        chk("rst_inv",      invert,     0);
        chk("rst_contrast", contrast,   8'h7F);
        chk("rst_mode",     addr_mode,  2);

        rst_n = 1'b1;
        @(negedge clk);
        ss = 1'b0;
        repeat (4) @(negedge clk);

        // First data byte lands at 0, the next at 1 (page mode)
        send_byte(8'h55, 1'b1);
        expect_write("d55", 10'd0, 8'h55);
        send_byte(8'hAA, 1'b1);
        expect_write("dAA", 10'd1, 8'hAA);

        // Horizontal mode, 2x2 window in the bottom-right corner
        send_byte(8'h20, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h21, 1'b0); send_byte(8'h7E, 1'b0); send_byte(8'h7F, 1'b0);
        send_byte(8'h22, 1'b0); send_byte(8'h06, 1'b0); send_byte(8'h07, 1'b0);
        chk("mode_horiz", addr_mode, 0);
        send_byte(8'h01, 1'b1); expect_write("h0", 10'd894,  8'h01);
        send_byte(8'h02, 1'b1); expect_write("h1", 10'd895,  8'h02);
        send_byte(8'h03, 1'b1); expect_write("h2", 10'd1022, 8'h03);
        send_byte(8'h04, 1'b1); expect_write("h3", 10'd1023, 8'h04);
        send_byte(8'h05, 1'b1); expect_write("h_wrap", 10'd894, 8'h05);

        // Vertical mode, full window: down column 0, then column 1
        send_byte(8'h20, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'h21, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h7F, 1'b0);
        send_byte(8'h22, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h07, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(8'h10 + i), 1'b1);
            expect_write("vert", 10'(i * 128), 8'(8'h10 + i));
        end
        send_byte(8'h18, 1'b1);
        expect_write("vert_wrap", 10'd1, 8'h18);

        // Page mode with page/column set commands: page 3, column 0x25
        send_byte(8'h20, 1'b0); send_byte(8'h02, 1'b0);
        send_byte(8'hB3, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'h12, 1'b0);
        chk("mode_page", addr_mode, 2);
        send_byte(8'hC3, 1'b1);
        expect_write("page_set", 10'd421, 8'hC3);

        // Partial byte aborted by chip select, then display-on command
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
        repeat (2) @(negedge clk);
        ss = 1'b1;
        repeat (6) @(negedge clk);
        ss = 1'b0;
        repeat (6) @(negedge clk);
        send_byte(8'hAF, 1'b0);
        repeat (4) @(negedge clk);
        chk("cs_abort_disp", display_on, 1);
        chk("cs_abort_nowrite", wq.size(), 0);
        wq.delete();

        // Contrast command interrupted by data: write happens, contrast kept
        send_byte(8'h81, 1'b0);
        send_byte(8'h33, 1'b1);
        expect_write("abort_write", 10'd422, 8'h33);
        chk("abort_contrast", contrast, 8'h7F);
        send_byte(8'h40, 1'b0);
        chk("abort_idle", contrast, 8'h7F);
        send_byte(8'h81, 1'b0); send_byte(8'h40, 1'b0);
        chk("contrast_set", contrast, 8'h40);
        send_byte(8'hA7, 1'b0);
        chk("invert_set", invert, 1);
        send_byte(8'h20, 1'b0); send_byte(8'h03, 1'b0);
        chk("mode3_ignored", addr_mode, 2);

        // Asynchronous reset in the middle of a byte
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_addr",     vram_addr,  0);
        chk("arst_data",     vram_data,  0);
        chk("arst_we",       vram_we,    0);
        chk("arst_disp",     display_on, 0);
        chk("arst_inv",      invert,     0);
        chk("arst_contrast", contrast,   8'h7F);
        chk("arst_mode",     addr_mode,  2);
        @(negedge clk);
        scl = 1'b0;
        ss  = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        ss = 1'b0;
        repeat (4) @(negedge clk);
        wq.delete();
        send_byte(8'h11, 1'b1);
        expect_write("post_rst", 10'd0, 8'h11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
